dht11_sensor_model: RTL and testbench
=====================================

// Module: dht11_sensor_model
// PURPOSE
//  Synthesizable DHT11 sensor responder: the device end of the single-wire DHT11 protocol.
//  Detects the host start pulse on open-drain data_io, then sends the response preamble and a
//  40-bit frame (hum_int, hum_dec, temp_int, temp_dec, checksum), MSB first.
//  Serves as a board-level sensor emulator and as the loopback target for dht11_driver benches.
// PARAMETERS
//  CLK_PER_US    1      clock cycles per microsecond (prescaler terminal count); must be >= 1
//  START_MIN_US  18000  minimum host low time accepted as a start request, in us
//  RESP_WAIT_US  30     delay from host release to response low, in us
//  BIT_LOW_US    50     low time preceding every data bit and the end-of-frame low, in us
//  ZERO_HIGH_US  26     high time encoding a 0 bit, in us
//  ONE_HIGH_US   70     high time encoding a 1 bit, in us
// PORTS
//  clk          in     1  system clock
//  rst_n        in     1  asynchronous active-low reset
//  data_io      inout  1  open-drain bus: drives 1'b0 or 1'bz only, never 1; external pull-up
//  enable       in     1  1 = respond to start requests; 0 = ignore the bus
//  hum_int      in     8  humidity integer byte
//  hum_dec      in     8  humidity decimal byte
//  temp_int     in     8  temperature integer byte
//  temp_dec     in     8  temperature decimal byte
//  bad_chk      in     1  1 = send the inverted checksum (error injection); sampled with the data
//  busy         out    1  high from start acceptance until the frame ends
//  frame_done   out    1  one-cycle pulse when the bus is released after the end-of-frame low
// BEHAVIOUR
//  - Reset: data_io released (z), busy=0, frame_done=0, FSM=IDLE, counters=0. Reset mid-frame
//    releases the line immediately and the partial frame is dropped.
//  - Input: 2-flop synchronizer on data_io; z or 1 reads as 1. Adds 2 cycles of detection latency.
//  - Timebase: prescaler counts 0..CLK_PER_US-1 and its wrap gives a 1-us tick. A 16-bit us
//    counter clears on every state change and saturates at 16'hFFFF.
//  - FSM:
//    IDLE      : if enable and synced line = 0 -> HOST_LOW.
//    HOST_LOW  : count low time. Line high before START_MIN_US -> IDLE (glitch, no response).
//                Line high at >= START_MIN_US -> latch the 4 bytes, bad_chk and
//                chk = hum_int+hum_dec+temp_int+temp_dec (mod 256, 8-bit wrap); busy=1; -> RESP_DLY.
//    RESP_DLY  : release; after RESP_WAIT_US -> RESP_LOW.
//    RESP_LOW  : drive 0 for 80 us -> RESP_HIGH.
//    RESP_HIGH : release for 80 us -> BIT_LOW; bit index = 39.
//    BIT_LOW   : drive 0 for BIT_LOW_US -> BIT_HIGH.
//    BIT_HIGH  : release for ZERO_HIGH_US or ONE_HIGH_US, chosen by shreg[39] (the current MSB).
//                On expiry: if index = 0 -> END_LOW; else shift shreg left by 1,
//                decrement index, -> BIT_LOW.
//    END_LOW   : drive 0 for BIT_LOW_US; then release, pulse frame_done, busy=0 -> IDLE.
//  - The 40-bit shift register holds {hum_int, hum_dec, temp_int, temp_dec, chk or ~chk}, MSB first.
//  - While busy, bus activity by the host is ignored, and a drop of enable does not abort the frame.
//    enable is sampled only in IDLE.
//  - A new start is accepted only after the FSM has returned to IDLE.
//  - The drive enable is registered, so data_io changes 1 cycle after the state change.
//  - Timing tolerance: each phase lasts its nominal value +0/+1 us.
// TESTING
//  Use CLK_PER_US=1 and START_MIN_US=20 for all scenarios.
//  1 Host low 25 us, then release; data 0x35,0x00,0x18,0x00 -> 30 us wait, 80 low, 80 high,
//    then 40 bits decoding to 35 00 18 00 4D; frame_done pulses once.
//  2 Host low 10 us (glitch) -> data_io stays z, busy stays 0, FSM returns to IDLE.
//  3 Data FF,FF,FF,FF -> checksum byte FC (8-bit wrap); all 32 data bits show 70-us highs.
//  4 bad_chk=1 with scenario-1 data -> checksum byte B2; payload bytes unchanged.
//  5 Assert rst_n=0 during bit 12 -> data_io is z within 0 cycles, busy=0; a new start after
//    reset yields a complete, correct frame.
//  6 enable=0 with a 25-us host low -> no response. With enable=1 at start and enable dropped
//    mid-frame -> the full frame is still sent.

Source files
------------

// File: rtl/dht11_sensor_model.sv
// Device end of the single-wire DHT11 protocol: waits for the host start pulse on the
// open-drain line, then answers with the response preamble and a 40-bit frame
// {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
module dht11_sensor_model #(
  parameter int unsigned CLK_PER_US   = 1,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned RESP_WAIT_US = 30,
  parameter int unsigned BIT_LOW_US   = 50,
  parameter int unsigned ZERO_HIGH_US = 26,
  parameter int unsigned ONE_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        data_io,
  input  logic       enable,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       bad_chk,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned RESP_US = 80;
  localparam int unsigned PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_RESP_DLY,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_us;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_drive_low;
  logic [1:0]       r_drv_hist;
  logic [39:0]      r_shreg;
  logic [5:0]       r_idx;
  logic             r_done_pend;

  logic             w_tick;
  logic [31:0]      w_elapsed;
  logic [31:0]      w_phase_len;
  logic             w_expired;
  logic             w_own_echo;
  logic [7:0]       w_chk;

  assign data_io = r_drive_low ? 1'b0 : 1'bz;

  assign w_tick    = (r_pre == PRE_W'(CLK_PER_US - 1));
  // Time spent in the current state, counting the microsecond now in progress.
  assign w_elapsed = {16'd0, r_us} + 32'd1;
  assign w_chk     = hum_int + hum_dec + temp_int + temp_dec;

  // Our own low drive takes three edges to clear the synchronizer; a low seen while it
  // is still in flight is our echo, not a host start.
  assign w_own_echo = r_drive_low | (|r_drv_hist);

  always_comb begin
    w_phase_len = RESP_US;
    case (r_state)
      S_RESP_DLY:             w_phase_len = RESP_WAIT_US;
      S_RESP_LOW,
      S_RESP_HIGH:            w_phase_len = RESP_US;
      S_BIT_LOW, S_END_LOW:   w_phase_len = BIT_LOW_US;
      S_BIT_HIGH:             w_phase_len = r_shreg[39] ? ONE_HIGH_US : ZERO_HIGH_US;
      default:                w_phase_len = RESP_US;
    endcase
  end

  assign w_expired = w_tick && (w_elapsed >= w_phase_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_us        <= '0;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_drive_low <= 1'b0;
      r_drv_hist  <= '0;
      r_shreg     <= '0;
      r_idx       <= '0;
      r_done_pend <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_sync1     <= data_io;
      r_sync2     <= r_sync1;
      r_pre       <= w_tick ? '0 : r_pre + 1'b1;
      r_drv_hist  <= {r_drv_hist[0], r_drive_low};
      r_drive_low <= (r_state == S_RESP_LOW) || (r_state == S_BIT_LOW) ||
                     (r_state == S_END_LOW);
      // Drive lags the state by one edge; done/busy are delayed to match the release.
      r_done_pend <= 1'b0;
      frame_done  <= r_done_pend;
      if (r_done_pend) begin
        busy <= 1'b0;
      end

      if (w_tick && (r_us != '1)) begin
        r_us <= r_us + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (enable && !r_sync2 && !w_own_echo) begin
            r_state <= S_HOST_LOW;
            r_us    <= '0;
          end
        end
        S_HOST_LOW: begin
          if (r_sync2) begin
            r_us <= '0;
            if (w_elapsed >= START_MIN_US) begin
              r_shreg <= {hum_int, hum_dec, temp_int, temp_dec, bad_chk ? ~w_chk : w_chk};
              busy    <= 1'b1;
              r_state <= S_RESP_DLY;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RESP_DLY: begin
          if (w_expired) begin
            r_state <= S_RESP_LOW;
            r_us    <= '0;
          end
        end
        S_RESP_LOW: begin
          if (w_expired) begin
            r_state <= S_RESP_HIGH;
            r_us    <= '0;
          end
        end
        S_RESP_HIGH: begin
          if (w_expired) begin
            r_state <= S_BIT_LOW;
            r_idx   <= 6'd39;
            r_us    <= '0;
          end
        end
        S_BIT_LOW: begin
          if (w_expired) begin
            r_state <= S_BIT_HIGH;
            r_us    <= '0;
          end
        end
        S_BIT_HIGH: begin
          if (w_expired) begin
            r_us <= '0;
            if (r_idx == '0) begin
              r_state <= S_END_LOW;
            end else begin
              r_shreg <= {r_shreg[38:0], 1'b0};
              r_idx   <= r_idx - 1'b1;
              r_state <= S_BIT_LOW;
            end
          end
        end
        S_END_LOW: begin
          if (w_expired) begin
            r_state     <= S_IDLE;
            r_us        <= '0;
            r_done_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_us    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sensor_model.sv
`timescale 1ns/1ps
module tb_dht11_sensor_model;

  localparam int unsigned START_MIN = 20;
  localparam int unsigned RESP_WAIT = 30;
  localparam int unsigned BIT_LOW   = 50;
  localparam int unsigned ZERO_H    = 26;
  localparam int unsigned ONE_H     = 70;
  localparam int unsigned RESP_US   = 80;
  localparam int unsigned RUN_LIMIT = 400;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       enable   = 1'b0;
  logic       bad_chk  = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hum_int  = '0;
  logic [7:0] hum_dec  = '0;
  logic [7:0] temp_int = '0;
  logic [7:0] temp_dec = '0;
  logic       busy;
  logic       frame_done;

  wire bus;
  pullup (bus);
  assign bus = host_low ? 1'b0 : 1'bz;

  dht11_sensor_model #(
    .CLK_PER_US  (1),
    .START_MIN_US(START_MIN),
    .RESP_WAIT_US(RESP_WAIT),
    .BIT_LOW_US  (BIT_LOW),
    .ZERO_HIGH_US(ZERO_H),
    .ONE_HIGH_US (ONE_H)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_io   (bus),
    .enable    (enable),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .temp_int  (temp_int),
    .temp_dec  (temp_dec),
    .bad_chk   (bad_chk),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned t_release = 0;
  int unsigned fd_cnt = 0;
  int          frames_started = 0;
  int          frames_seen = 0;
  int          mon_bit = -1;
  logic [39:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act,
                             input int unsigned lo, input int unsigned hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic run_len(input logic level, output int unsigned len, output bit aborted);
    len = 1;
    aborted = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aborted = 1'b1;
        return;
      end
      if (bus !== level) return;
      len++;
      if (len >= RUN_LIMIT) return;
    end
  endtask

  task automatic decode_frame();
    int unsigned len;
    int unsigned eh;
    bit          ab;
    bit          have_exp;
    logic [39:0] got;
    logic [39:0] exp;
    int unsigned fd0;
    frames_started++;
    fd0      = fd_cnt;
    have_exp = (exp_q.size() > 0);
    exp      = have_exp ? exp_q[0] : '0;
    got      = '0;
    check("frame_expected", {63'd0, have_exp}, 64'd1);
    // 30 us wait + 2 sync flops + 1 detect edge + 1 registered drive, +1 us tolerance
    check_range("resp_wait", cyc - t_release, RESP_WAIT, RESP_WAIT + 5);
    run_len(1'b0, len, ab);
    if (!ab) check_range("resp_low", len, RESP_US, RESP_US + 1);
    if (!ab) begin
      run_len(1'b1, len, ab);
      if (!ab) check_range("resp_high", len, RESP_US, RESP_US + 1);
    end
    for (int i = 0; i < 40 && !ab; i++) begin
      mon_bit = i;
      run_len(1'b0, len, ab);
      if (ab) break;
      check_range("bit_low", len, BIT_LOW, BIT_LOW + 1);
      run_len(1'b1, len, ab);
      if (ab) break;
      got = {got[38:0], (len > (ZERO_H + ONE_H) / 2)};
      eh  = exp[39 - i] ? ONE_H : ZERO_H;
      check_range("bit_high", len, eh, eh + 1);
    end
    if (!ab) begin
      run_len(1'b0, len, ab);
      if (!ab) check_range("end_low", len, BIT_LOW, BIT_LOW + 1);
    end
    if (ab) begin
      if (have_exp) void'(exp_q.pop_front());
    end else begin
      repeat (3) @(negedge clk);
      check("frame_done_pulses", fd_cnt - fd0, 64'd1);
      check("frame_data", got, exp);
      if (have_exp) void'(exp_q.pop_front());
    end
    mon_bit = -1;
    frames_seen++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && !host_low && bus === 1'b0) decode_frame();
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_data(input logic [7:0] hi, input logic [7:0] hd,
                          input logic [7:0] ti, input logic [7:0] td, input logic bc);
    hum_int  = hi;
    hum_dec  = hd;
    temp_int = ti;
    temp_dec = td;
    bad_chk  = bc;
  endtask

  task automatic host_start(input int unsigned low_us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low_us) @(negedge clk);
    host_low  = 1'b0;
    t_release = cyc;
  endtask

  task automatic wait_frames(input int target, input string name);
    int unsigned k = 0;
    while (frames_seen < target && k < 8000) begin
      @(negedge clk);
      k++;
    end
    check(name, frames_seen, target);
  endtask

  task automatic wait_bit(input int b, input string name);
    int unsigned k = 0;
    while (mon_bit != b && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, mon_bit, b);
  endtask

  task automatic quiet_window(input string tag);
    int   started0;
    logic busy_seen;
    started0  = frames_started;
    busy_seen = 1'b0;
    repeat (250) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check({tag, "_busy"}, busy_seen, 64'd0);
    check({tag, "_no_frame"}, frames_started, started0);
    check({tag, "_bus_z"}, bus, 64'd1);
  endtask

  initial begin : stimulus
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_busy", busy, 64'd0);
    check("reset_frame_done", frame_done, 64'd0);
    check("reset_bus_z", bus, 64'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: nominal frame
    set_data(8'h35, 8'h00, 8'h18, 8'h00, 1'b0);
    exp_q.push_back(40'h35_00_18_00_4D);
    host_start(25);
    repeat (40) @(negedge clk);
    check("s1_busy_during", busy, 64'd1);
    wait_frames(1, "s1_frame");
    repeat (5) @(negedge clk);
    check("s1_busy_after", busy, 64'd0);
    repeat (20) @(negedge clk);

    // 2: glitch shorter than the start minimum
    host_start(10);
    quiet_window("s2");

    // 3: checksum wraps
    set_data(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    exp_q.push_back(40'hFF_FF_FF_FF_FC);
    host_start(25);
    wait_frames(2, "s3_frame");
    repeat (20) @(negedge clk);

    // 4: checksum error injection
    set_data(8'h35, 8'h00, 8'h18, 8'h00, 1'b1);
    exp_q.push_back(40'h35_00_18_00_B2);
    host_start(25);
    wait_frames(3, "s4_frame");
    bad_chk = 1'b0;
    repeat (20) @(negedge clk);

    // 5: reset during bit 12 drops the frame, then a fresh frame
    set_data(8'h35, 8'h00, 8'h18, 8'h00, 1'b0);
    exp_q.push_back(40'h35_00_18_00_4D);
    host_start(25);
    wait_bit(12, "s5_reach_bit12");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_reset_bus_z", bus, 64'd1);
    check("s5_reset_busy", busy, 64'd0);
    wait_frames(4, "s5_aborted");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    check("s5_dropped", exp_q.size(), 64'd0);
    repeat (10) @(negedge clk);
    exp_q.push_back(40'h35_00_18_00_4D);
    host_start(25);
    wait_frames(5, "s5_frame_after_reset");
    repeat (20) @(negedge clk);

    // 6a: disabled responder ignores the start
    enable = 1'b0;
    host_start(25);
    quiet_window("s6_disabled");
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // 6b: enable dropped mid-frame does not abort
    set_data(8'h41, 8'h07, 8'h1A, 8'h03, 1'b0);
    exp_q.push_back(40'h41_07_1A_03_65);
    host_start(25);
    wait_bit(5, "s6_reach_bit5");
    enable = 1'b0;
    wait_frames(6, "s6_frame");
    enable = 1'b1;
    repeat (20) @(negedge clk);

    check("queue_empty", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
